wb_commit_unit: RTL and testbench



---
 rtl/wb_commit_unit.sv | 205 ++++++++++++++++++++
 tb/tb_wb_commit_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_commit_unit.sv
// Writeback/commit stage: selects the writeback value, updates the GPR file and the M-mode CSR
// subset, raises ecall/mret redirects and publishes a registered commit record with instret.
module wb_commit_unit #(
   parameter logic [31:0] RESET_MSTATUS = 32'h0000_1800,
   parameter logic [31:0] ECALL_CAUSE   = 32'd11
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_i_reg_wen,
   input  logic [4:0]  wb_i_rd,
   input  logic [11:0] wb_i_csr_rd,
   input  logic [2:0]  wb_i_csr_sel,
   input  logic [1:0]  wb_i_valD_sel,
   input  logic [31:0] wb_i_valE,
   input  logic [31:0] wb_i_valM,
   input  logic [31:0] wb_i_pc,
   input  logic [31:0] wb_i_instr,
   input  logic        wb_i_commit,
   input  logic [31:0] wb_i_pre_pc,
   input  logic [4:0]  dec_i_rs1,
   input  logic [4:0]  dec_i_rs2,
   output logic [31:0] dec_o_rdata1,
   output logic [31:0] dec_o_rdata2,
   input  logic [11:0] dec_i_csr_raddr,
   output logic [31:0] dec_o_csr_rdata,
   output logic [31:0] wb_o_valD,
   output logic        wb_o_redirect,
   output logic [31:0] wb_o_redirect_pc,
   output logic        cmt_o_valid,
   output logic [31:0] cmt_o_pc,
   output logic [31:0] cmt_o_instr,
   output logic [31:0] cmt_o_next_pc,
   output logic [63:0] cmt_o_instret
);

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;

   localparam logic [2:0] SEL_CSRRW = 3'd1;
   localparam logic [2:0] SEL_CSRRS = 3'd2;
   localparam logic [2:0] SEL_CSRRC = 3'd3;
   localparam logic [2:0] SEL_ECALL = 3'd4;
   localparam logic [2:0] SEL_MRET  = 3'd5;

   // There is no backpressure: wb_i_commit is the sole valid qualifier for the W bundle. When it
   // is low every other wb_i_* field is ignored for state updates; nothing is ever stalled here.

   logic [31:0] gpr [32];
   logic [31:0] mstatus, mtvec, mepc, mcause;
   logic [31:0] mstatus_nxt, mtvec_nxt, mepc_nxt, mcause_nxt;
   logic [31:0] csr_old, csr_wdata;
   logic        csr_op, is_ecall, is_mret, gpr_we;

   function automatic logic [31:0] csr_lookup(input logic [11:0] addr,
                                              input logic [31:0] v_mstatus,
                                              input logic [31:0] v_mtvec,
                                              input logic [31:0] v_mepc,
                                              input logic [31:0] v_mcause);
      logic [31:0] r;
      r = 32'd0;
      case (addr)
         CSR_MSTATUS: r = v_mstatus;
         CSR_MTVEC:   r = v_mtvec;
         CSR_MEPC:    r = v_mepc;
         CSR_MCAUSE:  r = v_mcause;
         default:     r = 32'd0;
      endcase
      return r;
   endfunction

   assign is_ecall = wb_i_commit && (wb_i_csr_sel == SEL_ECALL);
   assign is_mret  = wb_i_commit && (wb_i_csr_sel == SEL_MRET);
   assign csr_op   = wb_i_commit && (wb_i_csr_sel == SEL_CSRRW || wb_i_csr_sel == SEL_CSRRS ||
                                     wb_i_csr_sel == SEL_CSRRC);
   assign gpr_we   = wb_i_commit && wb_i_reg_wen && (wb_i_rd != 5'd0);

   assign csr_old = csr_lookup(wb_i_csr_rd, mstatus, mtvec, mepc, mcause);

   always_comb begin
      csr_wdata = wb_i_valE;
      case (wb_i_csr_sel)
         SEL_CSRRS: csr_wdata = csr_old | wb_i_valE;
         SEL_CSRRC: csr_wdata = csr_old & ~wb_i_valE;
         default:   csr_wdata = wb_i_valE;
      endcase
   end

   // Next-state CSR values already include the commit gate, so they double as the
   // decode-side write-through view.
   always_comb begin
      mstatus_nxt = mstatus;
      mtvec_nxt   = mtvec;
      mepc_nxt    = mepc;
      mcause_nxt  = mcause;
      if (csr_op) begin
         case (wb_i_csr_rd)
            CSR_MSTATUS: mstatus_nxt = csr_wdata;
            CSR_MTVEC:   mtvec_nxt   = csr_wdata;
            CSR_MEPC:    mepc_nxt    = csr_wdata;
            CSR_MCAUSE:  mcause_nxt  = csr_wdata;
            default:     ;
         endcase
      end
      if (is_ecall) begin
         mepc_nxt           = wb_i_pc;
         mcause_nxt         = ECALL_CAUSE;
         mstatus_nxt[7]     = mstatus[3];
         mstatus_nxt[3]     = 1'b0;
         mstatus_nxt[12:11] = 2'b11;
      end
      if (is_mret) begin
         mstatus_nxt[3]     = mstatus[7];
         mstatus_nxt[7]     = 1'b1;
         mstatus_nxt[12:11] = 2'b11;
      end
   end

   assign dec_o_csr_rdata = csr_lookup(dec_i_csr_raddr, mstatus_nxt, mtvec_nxt, mepc_nxt,
                                       mcause_nxt);

   always_comb begin
      wb_o_valD = wb_i_valE;
      case (wb_i_valD_sel)
         2'd0: wb_o_valD = wb_i_valE;
         2'd1: wb_o_valD = wb_i_valM;
         2'd2: wb_o_valD = wb_i_pc + 32'd4;
         2'd3: wb_o_valD = csr_old;
         default: wb_o_valD = wb_i_valE;
      endcase
   end

   always_comb begin
      wb_o_redirect    = is_ecall || is_mret;
      wb_o_redirect_pc = 32'd0;
      if (is_ecall) begin
         wb_o_redirect_pc = mtvec;
      end else if (is_mret) begin
         wb_o_redirect_pc = mepc;
      end
   end

   always_comb begin
      dec_o_rdata1 = gpr[dec_i_rs1];
      if (dec_i_rs1 == 5'd0) begin
         dec_o_rdata1 = 32'd0;
      end else if (gpr_we && dec_i_rs1 == wb_i_rd) begin
         dec_o_rdata1 = wb_o_valD;
      end
   end

   always_comb begin
      dec_o_rdata2 = gpr[dec_i_rs2];
      if (dec_i_rs2 == 5'd0) begin
         dec_o_rdata2 = 32'd0;
      end else if (gpr_we && dec_i_rs2 == wb_i_rd) begin
         dec_o_rdata2 = wb_o_valD;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            gpr[i] <= 32'd0;
         end
      end else if (gpr_we) begin
         gpr[wb_i_rd] <= wb_o_valD;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mstatus <= RESET_MSTATUS;
         mtvec   <= 32'd0;
         mepc    <= 32'd0;
         mcause  <= 32'd0;
      end else begin
         mstatus <= mstatus_nxt;
         mtvec   <= mtvec_nxt;
         mepc    <= mepc_nxt;
         mcause  <= mcause_nxt;
      end
   end

   // Commit record: pc/instr/next_pc hold their last committed values across bubbles.
   always_ff @(posedge clk) begin
      if (rst) begin
         cmt_o_valid   <= 1'b0;
         cmt_o_pc      <= 32'd0;
         cmt_o_instr   <= 32'd0;
         cmt_o_next_pc <= 32'd0;
         cmt_o_instret <= 64'd0;
      end else if (wb_i_commit) begin
         cmt_o_valid   <= 1'b1;
         cmt_o_pc      <= wb_i_pc;
         cmt_o_instr   <= wb_i_instr;
         cmt_o_next_pc <= wb_o_redirect ? wb_o_redirect_pc : wb_i_pre_pc;
         cmt_o_instret <= cmt_o_instret + 64'd1;
      end else begin
         cmt_o_valid   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_wb_commit_unit.sv
// Directed bench for wb_commit_unit: a table of single-cycle vectors plus hand-written
// sequences for reset behaviour and back-to-back commits.
module tb_wb_commit_unit;

   logic        clk;
   logic        rst;
   logic        wb_i_reg_wen;
   logic [4:0]  wb_i_rd;
   logic [11:0] wb_i_csr_rd;
   logic [2:0]  wb_i_csr_sel;
   logic [1:0]  wb_i_valD_sel;
   logic [31:0] wb_i_valE, wb_i_valM, wb_i_pc, wb_i_instr, wb_i_pre_pc;
   logic        wb_i_commit;
   logic [4:0]  dec_i_rs1, dec_i_rs2;
   logic [31:0] dec_o_rdata1, dec_o_rdata2;
   logic [11:0] dec_i_csr_raddr;
   logic [31:0] dec_o_csr_rdata, wb_o_valD;
   logic        wb_o_redirect;
   logic [31:0] wb_o_redirect_pc;
   logic        cmt_o_valid;
   logic [31:0] cmt_o_pc, cmt_o_instr, cmt_o_next_pc;
   logic [63:0] cmt_o_instret;

   int n_pass = 0;
   int n_total = 0;
   logic [63:0] exp_q[$];

   wb_commit_unit dut (
      .clk(clk), .rst(rst),
      .wb_i_reg_wen(wb_i_reg_wen), .wb_i_rd(wb_i_rd), .wb_i_csr_rd(wb_i_csr_rd),
      .wb_i_csr_sel(wb_i_csr_sel), .wb_i_valD_sel(wb_i_valD_sel), .wb_i_valE(wb_i_valE),
      .wb_i_valM(wb_i_valM), .wb_i_pc(wb_i_pc), .wb_i_instr(wb_i_instr),
      .wb_i_commit(wb_i_commit), .wb_i_pre_pc(wb_i_pre_pc),
      .dec_i_rs1(dec_i_rs1), .dec_i_rs2(dec_i_rs2),
      .dec_o_rdata1(dec_o_rdata1), .dec_o_rdata2(dec_o_rdata2),
      .dec_i_csr_raddr(dec_i_csr_raddr), .dec_o_csr_rdata(dec_o_csr_rdata),
      .wb_o_valD(wb_o_valD), .wb_o_redirect(wb_o_redirect), .wb_o_redirect_pc(wb_o_redirect_pc),
      .cmt_o_valid(cmt_o_valid), .cmt_o_pc(cmt_o_pc), .cmt_o_instr(cmt_o_instr),
      .cmt_o_next_pc(cmt_o_next_pc), .cmt_o_instret(cmt_o_instret)
   );

   // clock / watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: act=timeout req=finish");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic        commit;
      logic        wen;
      logic [4:0]  rd;
      logic [11:0] crd;
      logic [2:0]  cs;
      logic [1:0]  vs;
      logic [31:0] vale;
      logic [31:0] valm;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] pre_pc;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [11:0] cra;
      logic [31:0] e_vald;
      logic [31:0] e_rd1;
      logic [31:0] e_rd2;
      logic        e_redir;
      logic [31:0] e_rpc;
      logic [31:0] e_csr;
      logic        e_cv;
      logic [31:0] e_cpc;
      logic [31:0] e_cins;
      logic [31:0] e_cnpc;
      logic [63:0] e_ret;
   } vec_t;

   localparam int NV = 14;
   vec_t tv [NV];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: act=%h req=%h", name, act, req);
   endtask

   task automatic drive(input logic commit, input logic wen, input logic [4:0] rd,
                        input logic [11:0] crd, input logic [2:0] cs, input logic [1:0] vs,
                        input logic [31:0] vale, input logic [31:0] valm, input logic [31:0] pc,
                        input logic [31:0] instr, input logic [31:0] pre_pc);
      wb_i_commit   = commit;
      wb_i_reg_wen  = wen;
      wb_i_rd       = rd;
      wb_i_csr_rd   = crd;
      wb_i_csr_sel  = cs;
      wb_i_valD_sel = vs;
      wb_i_valE     = vale;
      wb_i_valM     = valm;
      wb_i_pc       = pc;
      wb_i_instr    = instr;
      wb_i_pre_pc   = pre_pc;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 5'd0, 12'h000, 3'd0, 2'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
   endtask

   task automatic apply_vec(input int i);
      vec_t v;
      v = tv[i];
      drive(v.commit, v.wen, v.rd, v.crd, v.cs, v.vs, v.vale, v.valm, v.pc, v.instr, v.pre_pc);
      dec_i_rs1       = v.rs1;
      dec_i_rs2       = v.rs2;
      dec_i_csr_raddr = v.cra;
      #1;
      check($sformatf("v%0d valD", i), {32'd0, wb_o_valD}, {32'd0, v.e_vald});
      check($sformatf("v%0d rdata1", i), {32'd0, dec_o_rdata1}, {32'd0, v.e_rd1});
      check($sformatf("v%0d rdata2", i), {32'd0, dec_o_rdata2}, {32'd0, v.e_rd2});
      check($sformatf("v%0d redirect", i), {63'd0, wb_o_redirect}, {63'd0, v.e_redir});
      check($sformatf("v%0d redirect_pc", i), {32'd0, wb_o_redirect_pc}, {32'd0, v.e_rpc});
      check($sformatf("v%0d csr_rdata", i), {32'd0, dec_o_csr_rdata}, {32'd0, v.e_csr});
      @(posedge clk);
      #1;
      check($sformatf("v%0d cmt_valid", i), {63'd0, cmt_o_valid}, {63'd0, v.e_cv});
      check($sformatf("v%0d cmt_pc", i), {32'd0, cmt_o_pc}, {32'd0, v.e_cpc});
      check($sformatf("v%0d cmt_instr", i), {32'd0, cmt_o_instr}, {32'd0, v.e_cins});
      check($sformatf("v%0d cmt_next_pc", i), {32'd0, cmt_o_next_pc}, {32'd0, v.e_cnpc});
      check($sformatf("v%0d instret", i), cmt_o_instret, v.e_ret);
      @(negedge clk);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, " cmt_valid"}, {63'd0, cmt_o_valid}, 64'd0);
      check({tag, " cmt_pc"}, {32'd0, cmt_o_pc}, 64'd0);
      check({tag, " cmt_instr"}, {32'd0, cmt_o_instr}, 64'd0);
      check({tag, " cmt_next_pc"}, {32'd0, cmt_o_next_pc}, 64'd0);
      check({tag, " instret"}, cmt_o_instret, 64'd0);
   endtask

   initial begin
      // columns: commit wen rd crd cs vs valE valM pc instr pre_pc rs1 rs2 cra |
      //          valD rdata1 rdata2 redirect redirect_pc csr_rdata | cv cpc cinstr cnext instret
      tv[0]  = '{1'b1, 1'b1, 5'd3, 12'h000, 3'd0, 2'd0, 32'hDEAD_BEEF, 32'h0, 32'h8000_0000, 32'hA000_0000, 32'h8000_0004, 5'd3, 5'd0, 12'h300,
                 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0, 1'b0, 32'h0, 32'h0000_1800, 1'b1, 32'h8000_0000, 32'hA000_0000, 32'h8000_0004, 64'd1};
      tv[1]  = '{1'b0, 1'b1, 5'd3, 12'h000, 3'd0, 2'd0, 32'h0000_1234, 32'h0, 32'h0BAD_0000, 32'hA000_0001, 32'h0BAD_0004, 5'd3, 5'd4, 12'h305,
                 32'h0000_1234, 32'hDEAD_BEEF, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h8000_0000, 32'hA000_0000, 32'h8000_0004, 64'd1};
      tv[2]  = '{1'b1, 1'b1, 5'd0, 12'h000, 3'd0, 2'd0, 32'h5, 32'h0, 32'h8000_0004, 32'hA000_0002, 32'h8000_0008, 5'd0, 5'd3, 12'h300,
                 32'h5, 32'h0, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'h0000_1800, 1'b1, 32'h8000_0004, 32'hA000_0002, 32'h8000_0008, 64'd2};
      tv[3]  = '{1'b0, 1'b1, 5'd4, 12'h305, 3'd1, 2'd0, 32'h77, 32'h0, 32'h8000_0008, 32'hA000_0003, 32'h8000_000C, 5'd4, 5'd0, 12'h305,
                 32'h77, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h8000_0004, 32'hA000_0002, 32'h8000_0008, 64'd2};
      tv[4]  = '{1'b1, 1'b1, 5'd1, 12'h305, 3'd1, 2'd3, 32'h8000_0100, 32'h0, 32'h8000_0008, 32'hA000_0004, 32'h8000_000C, 5'd4, 5'd1, 12'h305,
                 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h8000_0100, 1'b1, 32'h8000_0008, 32'hA000_0004, 32'h8000_000C, 64'd3};
      tv[5]  = '{1'b1, 1'b1, 5'd1, 12'h305, 3'd2, 2'd3, 32'h4, 32'h0, 32'h8000_000C, 32'hA000_0005, 32'h8000_0010, 5'd1, 5'd3, 12'h305,
                 32'h8000_0100, 32'h8000_0100, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'h8000_0104, 1'b1, 32'h8000_000C, 32'hA000_0005, 32'h8000_0010, 64'd4};
      tv[6]  = '{1'b1, 1'b1, 5'd2, 12'h305, 3'd3, 2'd3, 32'h4, 32'h0, 32'h8000_0020, 32'hA000_0006, 32'h8000_0024, 5'd1, 5'd2, 12'h305,
                 32'h8000_0104, 32'h8000_0100, 32'h8000_0104, 1'b0, 32'h0, 32'h8000_0100, 1'b1, 32'h8000_0020, 32'hA000_0006, 32'h8000_0024, 64'd5};
      tv[7]  = '{1'b1, 1'b0, 5'd0, 12'h300, 3'd1, 2'd3, 32'h0000_1808, 32'h0, 32'h8000_0024, 32'hA000_0007, 32'h8000_0028, 5'd2, 5'd0, 12'h300,
                 32'h0000_1800, 32'h8000_0104, 32'h0, 1'b0, 32'h0, 32'h0000_1808, 1'b1, 32'h8000_0024, 32'hA000_0007, 32'h8000_0028, 64'd6};
      tv[8]  = '{1'b1, 1'b0, 5'd0, 12'h000, 3'd4, 2'd0, 32'h0, 32'h0, 32'h8000_0010, 32'hA000_0008, 32'h8000_0014, 5'd0, 5'd0, 12'h341,
                 32'h0, 32'h0, 32'h0, 1'b1, 32'h8000_0100, 32'h8000_0010, 1'b1, 32'h8000_0010, 32'hA000_0008, 32'h8000_0100, 64'd7};
      tv[9]  = '{1'b0, 1'b0, 5'd0, 12'h000, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'hA000_0009, 32'h0, 5'd2, 5'd1, 12'h342,
                 32'h0, 32'h8000_0104, 32'h8000_0100, 1'b0, 32'h0, 32'd11, 1'b0, 32'h8000_0010, 32'hA000_0008, 32'h8000_0100, 64'd7};
      tv[10] = '{1'b0, 1'b0, 5'd0, 12'h000, 3'd0, 2'd2, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'hA000_000A, 32'h0, 5'd0, 5'd0, 12'h300,
                 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0000_1880, 1'b0, 32'h8000_0010, 32'hA000_0008, 32'h8000_0100, 64'd7};
      tv[11] = '{1'b1, 1'b1, 5'd5, 12'h000, 3'd5, 2'd1, 32'h0, 32'hCAFE_F00D, 32'h8000_0100, 32'hA000_000B, 32'h8000_0104, 5'd5, 5'd0, 12'h300,
                 32'hCAFE_F00D, 32'hCAFE_F00D, 32'h0, 1'b1, 32'h8000_0010, 32'h0000_1888, 1'b1, 32'h8000_0100, 32'hA000_000B, 32'h8000_0010, 64'd8};
      tv[12] = '{1'b1, 1'b1, 5'd6, 12'h7C0, 3'd1, 2'd3, 32'hFFFF_FFFF, 32'h0, 32'h8000_0010, 32'hA000_000C, 32'h8000_0014, 5'd6, 5'd5, 12'h7C0,
                 32'h0, 32'h0, 32'hCAFE_F00D, 1'b0, 32'h0, 32'h0, 1'b1, 32'h8000_0010, 32'hA000_000C, 32'h8000_0014, 64'd9};
      tv[13] = '{1'b1, 1'b1, 5'd7, 12'h341, 3'd6, 2'd2, 32'h0, 32'h0, 32'hFFFF_FFFE, 32'hA000_000D, 32'h0000_0002, 5'd7, 5'd0, 12'h341,
                 32'h2, 32'h2, 32'h0, 1'b0, 32'h0, 32'h8000_0010, 1'b1, 32'hFFFF_FFFE, 32'hA000_000D, 32'h0000_0002, 64'd10};

      // reset
      rst = 1'b1;
      idle();
      dec_i_rs1 = 5'd5;
      dec_i_rs2 = 5'd0;
      dec_i_csr_raddr = 12'h300;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_reset_state("reset");
      check("reset rdata1 x5", {32'd0, dec_o_rdata1}, 64'd0);
      check("reset mstatus", {32'd0, dec_o_csr_rdata}, 64'h1800);
      @(negedge clk);

      for (int i = 0; i < NV; i++) apply_vec(i);

      // rst asserted while W holds a real instruction: the instruction is dropped
      rst = 1'b1;
      drive(1'b1, 1'b1, 5'd3, 12'h305, 3'd1, 2'd0, 32'h1, 32'h0, 32'h8000_0200, 32'hB000_0000, 32'h8000_0204);
      @(posedge clk);
      #1;
      check_reset_state("midrst");
      @(negedge clk);
      rst = 1'b0;
      idle();
      dec_i_rs1 = 5'd3;
      dec_i_rs2 = 5'd1;
      dec_i_csr_raddr = 12'h305;
      #1;
      check("midrst x3", {32'd0, dec_o_rdata1}, 64'd0);
      check("midrst x1", {32'd0, dec_o_rdata2}, 64'd0);
      check("midrst mtvec", {32'd0, dec_o_csr_rdata}, 64'd0);
      @(negedge clk);

      // back-to-back commits
      for (int k = 1; k <= 3; k++) exp_q.push_back(64'(k));
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 1'b0, 5'd0, 12'h000, 3'd0, 2'd0, 32'h0, 32'h0, 32'h8000_1000 + 32'(4 * k),
               32'hC000_0000 + 32'(k), 32'h8000_1004 + 32'(4 * k));
         @(posedge clk);
         #1;
         check($sformatf("b2b%0d cmt_valid", k), {63'd0, cmt_o_valid}, 64'd1);
         check($sformatf("b2b%0d cmt_pc", k), {32'd0, cmt_o_pc}, {32'd0, 32'h8000_1000 + 32'(4 * k)});
         if (exp_q.size() == 0) check($sformatf("b2b%0d queue", k), 64'd0, 64'd1);
         else check($sformatf("b2b%0d instret", k), cmt_o_instret, exp_q.pop_front());
         @(negedge clk);
      end
      idle();
      @(posedge clk);
      #1;
      check("b2b end cmt_valid", {63'd0, cmt_o_valid}, 64'd0);
      check("b2b end instret", cmt_o_instret, 64'd3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
